univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/usr_pkg.sv | 26 ++
 rtl/usr_bit_counter.sv | 39 +++
 rtl/univ_shift_reg.sv | 147 ++++++++++++++
 tb/tb_univ_shift_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
//------------------------------------------------------------------------------
// Module   : usr_pkg
// Brief    : Shared mode encodings and burst FSM state type for the
//            universal shift register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package usr_pkg;

  // Manual operation selected by the mode input while the FSM is idle
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Burst sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } usr_state_t;

endpackage

`default_nettype wire

// File: rtl/usr_bit_counter.sv
//------------------------------------------------------------------------------
// Module   : usr_bit_counter
// Brief    : Loadable down-counter that saturates at zero; tracks the number
//            of shifts remaining in a burst.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module usr_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;

  // Load has priority over decrement; decrement stops at zero so it never wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg.sv
//------------------------------------------------------------------------------
// Module   : univ_shift_reg
// Brief    : Universal shift register with manual hold/shift/load modes and an
//            automatic load-then-shift-out burst sequencer.
//            Optional feature macro USR_ROTATE_EN adds a rot input that makes
//            every shift recirculate the bit shifted out instead of using the
//            serial inputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
`ifdef USR_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [WIDTH-1:0] pdin,
  input  logic             start,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  usr_state_t       r_state;
  usr_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_dir;
  logic             w_dir_nxt;

  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_zero;
  logic             w_cnt_last;

  logic             w_fill_r;
  logic             w_fill_l;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;

  // Fill bits: rotation recirculates the bit leaving the opposite end
`ifdef USR_ROTATE_EN
  assign w_fill_r = rot ? r_q[0]       : sin_r;
  assign w_fill_l = rot ? r_q[WIDTH-1] : sin_l;
`else
  assign w_fill_r = sin_r;
  assign w_fill_l = sin_l;
`endif

  assign w_shr = {w_fill_r, r_q[WIDTH-1:1]};
  assign w_shl = {r_q[WIDTH-2:0], w_fill_l};

  // The shift that takes the count from 1 to 0 is the last of the burst;
  // the zero term only guards against an impossible empty count in SHIFT.
  assign w_cnt_last = (w_cnt == CNT_W'(1)) || w_cnt_zero;

  usr_bit_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_cnt_load),
    .dec      (w_cnt_dec),
    .load_val (CNT_INIT),
    .count    (w_cnt),
    .zero     (w_cnt_zero)
  );

  // Next-state, data path and counter control; nothing moves without en
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_dir_nxt   = r_dir;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    if (en) begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_q_nxt     = pdin;
            w_dir_nxt   = dir;
            w_cnt_load  = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            case (mode)
              MODE_SHR:  w_q_nxt = w_shr;
              MODE_SHL:  w_q_nxt = w_shl;
              MODE_LOAD: w_q_nxt = pdin;
              default:   w_q_nxt = r_q;
            endcase
          end
        end
        ST_SHIFT: begin
          w_q_nxt   = r_dir ? w_shl : w_shr;
          w_cnt_dec = 1'b1;
          if (w_cnt_last) begin
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, data and latched direction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  assign q      = r_q;
  assign sout_r = r_q[0];
  assign sout_l = r_q[WIDTH-1];
  assign busy   = (r_state == ST_SHIFT);
  assign done   = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
//------------------------------------------------------------------------------
// Module   : tb_univ_shift_reg
// Brief    : Directed self-checking bench for univ_shift_reg (WIDTH=8).
//            Rotation steps are present only when USR_ROTATE_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
`ifdef USR_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] pdin;
  logic             start;
  logic             dir;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
`ifdef USR_ROTATE_EN
    .rot    (rot),
`endif
    .pdin   (pdin),
    .start  (start),
    .dir    (dir),
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] bits;
    int               hi;
    int               n;
    bit               seen;
    bit               spurious;

    // ---------------- reset, with en low ----------------
    rst_n = 1'b0; en = 1'b0; mode = MODE_HOLD; start = 1'b0; dir = 1'b0;
    sin_r = 1'b0; sin_l = 1'b0; pdin = '0;
`ifdef USR_ROTATE_EN
    rot = 1'b0;
`endif
    tick(); tick();
    chk("rst_q", q, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1; en = 1'b1;

    // ---------------- manual modes ----------------
    mode = MODE_LOAD; pdin = 8'hA5; tick();
    chk("man_load", q, 8'hA5);
    chk("man_sout_r", sout_r, 1'b1);
    chk("man_sout_l", sout_l, 1'b1);
    mode = MODE_SHR; sin_r = 1'b1; tick();
    chk("man_shr", q, 8'hD2);
    chk("man_shr_sout_r", sout_r, 1'b0);
    mode = MODE_SHL; sin_l = 1'b0; tick();
    chk("man_shl", q, 8'hA4);
    mode = MODE_HOLD; tick();
    chk("man_hold", q, 8'hA4);
    en = 1'b0; mode = MODE_LOAD; pdin = 8'hFF; tick();
    chk("man_en_low", q, 8'hA4);
    en = 1'b1; mode = MODE_HOLD;

    // ---------------- right burst ----------------
    pdin = 8'hB4; dir = 1'b0; sin_r = 1'b0; start = 1'b1; tick();
    start = 1'b0; pdin = 8'h00;
    chk("rb_busy", busy, 1'b1);
    chk("rb_load", q, 8'hB4);
    bits = 8'hB4;
    for (int i = 0; i < WIDTH; i++) begin
      chk($sformatf("rb_sout_r%0d", i), sout_r, bits[i]);
      chk($sformatf("rb_nodone%0d", i), done, 1'b0);
      tick();
    end
    chk("rb_done", done, 1'b1);
    chk("rb_busy_off", busy, 1'b0);
    chk("rb_q", q, 8'h00);
    tick();
    chk("rb_done_pulse", done, 1'b0);
    chk("rb_q_held", q, 8'h00);

    // ---------------- left burst, en toggling ----------------
    pdin = 8'h81; dir = 1'b1; sin_l = 1'b1; sin_r = 1'b0; start = 1'b1; tick();
    start = 1'b0;
    hi = 1; n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      en = 1'b0; tick();
      if (n == 0) chk("lb_stall_busy", busy, 1'b1);
      en = 1'b1; tick();
      hi++;
      if (done) seen = 1'b1;
      n++;
    end
    chk("lb_done_seen", seen, 1'b1);
    chk("lb_en_high_cycles", hi, 9);
    chk("lb_q", q, 8'hFF);
    tick();
    chk("lb_idle", done, 1'b0);

    // ---------------- start/load/dir ignored while busy ----------------
    pdin = 8'h5A; dir = 1'b0; sin_r = 1'b1; sin_l = 1'b0; start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    start = 1'b1; mode = MODE_LOAD; pdin = 8'h00; dir = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (done) seen = 1'b1;
    end
    chk("ig_done_seen", seen, 1'b1);
    chk("ig_done_cycle", n, 6);
    chk("ig_q", q, 8'hFF);
    start = 1'b0; mode = MODE_HOLD; dir = 1'b0;
    tick();

    // ---------------- reset mid-burst ----------------
    pdin = 8'hC3; start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    spurious = 1'b0;
    rst_n = 1'b0; tick();
    if (done) spurious = 1'b1;
    tick();
    chk("mr_q", q, 8'h00);
    chk("mr_busy", busy, 1'b0);
    chk("mr_done", done, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) spurious = 1'b1;
    end
    chk("mr_no_done", spurious, 1'b0);
    chk("mr_q_after", q, 8'h00);

`ifdef USR_ROTATE_EN
    // ---------------- rotation ----------------
    rot = 1'b1; sin_r = 1'b0; sin_l = 1'b0;
    mode = MODE_LOAD; pdin = 8'h01; tick();
    mode = MODE_SHR; tick();
    chk("rot_man_shr", q, 8'h80);
    mode = MODE_SHL; tick();
    chk("rot_man_shl", q, 8'h01);
    mode = MODE_HOLD;
    pdin = 8'h3C; dir = 1'b0; start = 1'b1; tick();
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) tick();
    chk("rot_done", done, 1'b1);
    chk("rot_q", q, 8'h3C);
    rot = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
